// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, dispatch unit selects and status-flag bit positions.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_HADD = 3'b001,
      OP_SUB  = 3'b010,
      OP_NOT  = 3'b011,
      OP_AND  = 3'b100,
      OP_OR   = 3'b101,
      OP_XOR  = 3'b110,
      OP_LHG  = 3'b111
   } alu_op_e;

   localparam logic [2:0] SEL_NONE    = 3'd0;
   localparam logic [2:0] ARITH_LOGIC = 3'd1;
   localparam logic [2:0] SEL_SHIFT   = 3'd2;
   localparam logic [2:0] SEL_MULT    = 3'd3;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_arith_core.sv
// Combinational arithmetic/logic kernel producing a result and {V,C,N,Z} status flags.
module alu_arith_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  alu_op_e          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int H = WIDTH / 2;

   logic [WIDTH:0] sum_w;
   logic [WIDTH:0] dif_w;
   logic [H:0]     hsum;
   logic           carry;
   logic           ovf;

   always_comb begin
      sum_w  = {1'b0, a} + {1'b0, b};
      dif_w  = {1'b0, a} - {1'b0, b};
      hsum   = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]};
      result = '0;
      carry  = 1'b0;
      ovf    = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum_w[WIDTH-1:0];
            carry  = sum_w[WIDTH];
            ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_HADD: begin
            result = {{H{hsum[H-1]}}, hsum[H-1:0]};
            carry  = hsum[H];
            ovf    = (a[H-1] == b[H-1]) && (hsum[H-1] != a[H-1]);
         end
         OP_SUB: begin
            // The extra top bit of the widened difference is the unsigned borrow.
            result = dif_w[WIDTH-1:0];
            carry  = dif_w[WIDTH];
            ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_NOT:  result = ~b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_LHG:  result = {b[H-1:0], {H{1'b0}}};
         default: result = '0;
      endcase
      flags         = '0;
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_N] = result[WIDTH-1];
      flags[FLAG_C] = carry;
      flags[FLAG_V] = ovf;
   end

endmodule

// File: rtl/alu_arith_pipe.sv
// Two-stage arithmetic/logic unit: S1 holds operands, S2 holds result and flags,
// with full back-pressure and a synchronous flush. WIDTH must be even and >= 8.
module alu_arith_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op_select,
   input  logic [2:0]       in_operation,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags
);

   logic             s1_valid_q, s1_valid_d;
   alu_op_e          s1_op_q, s1_op_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_result_q, s2_result_d;
   logic [3:0]       s2_flags_q, s2_flags_d;

   logic             accept;
   logic             s1_advance;
   logic             out_pop;
   logic [WIDTH-1:0] core_result;
   logic [3:0]       core_flags;

   alu_arith_core #(.WIDTH(WIDTH)) u_core (
      .op     (s1_op_q),
      .a      (s1_a_q),
      .b      (s1_b_q),
      .result (core_result),
      .flags  (core_flags)
   );

   // Handshake: a beat transfers on a rising edge where valid & ready are both high;
   // valid never depends on ready, and in_ready looks through S2 to out_ready so a
   // full pipe can take a new beat in the same cycle the consumer pops.
   always_comb begin
      s1_advance = s1_valid_q & (~s2_valid_q | out_ready);
      in_ready   = ~s1_valid_q | s1_advance;
      accept     = in_valid & in_ready & (in_op_select == ARITH_LOGIC) & ~flush;
      out_pop    = s2_valid_q & out_ready;

      s1_valid_d  = s1_valid_q;
      s1_op_d     = s1_op_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s2_valid_d  = s2_valid_q;
      s2_result_d = s2_result_q;
      s2_flags_d  = s2_flags_q;

      if (accept) begin
         s1_op_d = alu_op_e'(in_operation);
         s1_a_d  = in_a;
         s1_b_d  = in_b;
      end
      if (s1_advance) begin
         s2_result_d = core_result;
         s2_flags_d  = core_flags;
      end

      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (accept)          s1_valid_d = 1'b1;
         else if (s1_advance) s1_valid_d = 1'b0;
         if (s1_advance)      s2_valid_d = 1'b1;
         else if (out_pop)    s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= OP_ADD;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_flags_q  <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s2_valid_q  <= s2_valid_d;
         s2_result_q <= s2_result_d;
         s2_flags_q  <= s2_flags_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_result = s2_result_q;
   assign out_flags  = s2_flags_q;

endmodule
